program_counter: RTL and testbench

Program counter register of the 16-bit MIPS datapath. Each rising clock edge it captures the next instruction address, which the fetch/branch logic computes, and presents the current fetch address to instruction memory. It also provides the sequential successor address (PC + instruction size) so that the fetch stage needs no separate adder.

---
 rtl/pc_pkg.sv | 14 +
 rtl/pc_incrementer.sv | 18 +
 rtl/program_counter.sv | 73 +++++++
 tb/tb_program_counter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared constants and types for the 16-bit MIPS program counter.
//   PC_ADDR_WIDTH  - address width of the fetch path
//   PC_INSTR_BYTES - instruction size in bytes (power of two)
//   PC_RESET_ADDR  - fetch address after reset
//   PC_ALIGN_BITS  - number of low address bits that must be zero
//   pc_addr_t      - address type
package pc_pkg;
  localparam int PC_ADDR_WIDTH  = 16;
  localparam int PC_INSTR_BYTES = 2;
  localparam logic [PC_ADDR_WIDTH-1:0] PC_RESET_ADDR = 16'h0000;
  localparam int PC_ALIGN_BITS  = $clog2(PC_INSTR_BYTES);

  typedef logic [PC_ADDR_WIDTH-1:0] pc_addr_t;
endpackage

// File: rtl/pc_incrementer.sv
// pc_incrementer: combinational sequential-successor adder for the PC.
// Ports:
//   addr_i [ADDR_WIDTH] - current PC
//   sum_o  [ADDR_WIDTH] - addr_i + INSTR_BYTES, modulo 2^ADDR_WIDTH (no carry-out)
module pc_incrementer
  import pc_pkg::*;
#(
  parameter int ADDR_WIDTH  = PC_ADDR_WIDTH,
  parameter int INSTR_BYTES = PC_INSTR_BYTES
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [ADDR_WIDTH-1:0] sum_o
);

  // Carry out of the top bit is dropped, so the successor wraps to zero.
  assign sum_o = addr_i + ADDR_WIDTH'(INSTR_BYTES);

endmodule

// File: rtl/program_counter.sv
// program_counter: PC register of the 16-bit MIPS datapath.
// Captures next_instruction_address every rising edge unless stalled, and
// presents the current fetch address plus its sequential successor.
// Optional feature macro: PC_ALIGN_CHECK_EN
//   defined   - misaligned loads have their low bits cleared and raise
//               misaligned_fault for the cycle the loaded PC is held
//   undefined - addresses load verbatim, misaligned_fault is constant 0
// Ports:
//   clk                      - clock, rising edge
//   reset                    - synchronous active-high reset (overrides stall)
//   stall                    - hold PC and fault flag when 1
//   next_instruction_address - address loaded on the next edge
//   instruction_address      - registered current PC
//   pc_plus_step             - instruction_address + INSTR_BYTES (combinational)
//   misaligned_fault         - registered alignment fault flag
module program_counter
  import pc_pkg::*;
#(
  parameter int ADDR_WIDTH = PC_ADDR_WIDTH,
  parameter int INSTR_BYTES = PC_INSTR_BYTES,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = PC_RESET_ADDR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [ADDR_WIDTH-1:0] next_instruction_address,
  output logic [ADDR_WIDTH-1:0] instruction_address,
  output logic [ADDR_WIDTH-1:0] pc_plus_step,
  output logic                  misaligned_fault
);

  // Mask form avoids a zero-width slice when INSTR_BYTES is 1.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INSTR_BYTES - 1);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  fault_q, fault_d;

  always_comb begin
    pc_d    = pc_q;
    fault_d = fault_q;
    if (!stall) begin
`ifdef PC_ALIGN_CHECK_EN
      pc_d    = next_instruction_address & ~ALIGN_MASK;
      fault_d = |(next_instruction_address & ALIGN_MASK);
`else
      pc_d    = next_instruction_address;
      fault_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_ADDR;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  assign instruction_address = pc_q;
  assign misaligned_fault    = fault_q;

  pc_incrementer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INSTR_BYTES(INSTR_BYTES)
  ) u_incrementer (
    .addr_i(pc_q),
    .sum_o (pc_plus_step)
  );

endmodule

// File: tb/tb_program_counter.sv
module tb_program_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [15:0] next_instruction_address = 16'h0000;
  logic [15:0] instruction_address;
  logic [15:0] pc_plus_step;
  logic        misaligned_fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] step;
    logic        fault;
  } exp_t;

  exp_t sb[$];

  // Reference state of the PC as the bench understands it.
  logic [15:0] mpc = 16'h0000;
  logic        mfault = 1'b0;

  program_counter dut (
    .clk                     (clk),
    .reset                   (reset),
    .stall                   (stall),
    .next_instruction_address(next_instruction_address),
    .instruction_address     (instruction_address),
    .pc_plus_step            (pc_plus_step),
    .misaligned_fault        (misaligned_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Drive one edge's inputs while clk is low, record the expectation,
  // then return 1 time unit after the rising edge.
  task automatic drive(input logic r, input logic s, input logic [15:0] n);
    exp_t e;
    @(negedge clk);
    reset = r;
    stall = s;
    next_instruction_address = n;
    if (r) begin
      mpc = 16'h0000;
      mfault = 1'b0;
    end else if (!s) begin
`ifdef PC_ALIGN_CHECK_EN
      mpc = {n[15:1], 1'b0};
      mfault = n[0];
`else
      mpc = n;
      mfault = 1'b0;
`endif
    end
    e.pc = mpc;
    e.step = mpc + 16'd2;
    e.fault = mfault;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    drive(1'b1, 1'b0, 16'h1234);
    e = sb.pop_front();
    checks += 3;
    if (instruction_address !== 16'h0000 || instruction_address !== e.pc) begin
      errors++; $display("FAIL reset_pc got %h exp %h", instruction_address, e.pc);
    end
    if (pc_plus_step !== 16'h0002) begin
      errors++; $display("FAIL reset_step got %h exp 0002", pc_plus_step);
    end
    if (misaligned_fault !== 1'b0) begin
      errors++; $display("FAIL reset_fault got %b exp 0", misaligned_fault);
    end
  endtask

  task automatic run_table(input string name, input logic [2:0] rs[], input logic [15:0] nx[]);
    exp_t e;
    for (int i = 0; i < nx.size(); i++) begin
      drive(rs[i][1], rs[i][0], nx[i]);
      e = sb.pop_front();
      checks += 3;
      if (instruction_address !== e.pc) begin
        errors++; $display("FAIL %s[%0d] pc got %h exp %h", name, i, instruction_address, e.pc);
      end
      if (pc_plus_step !== e.step) begin
        errors++; $display("FAIL %s[%0d] step got %h exp %h", name, i, pc_plus_step, e.step);
      end
      if (misaligned_fault !== e.fault) begin
        errors++; $display("FAIL %s[%0d] fault got %b exp %b", name, i, misaligned_fault, e.fault);
      end
    end
  endtask

  // rs encoding: bit1 = reset, bit0 = stall
  task automatic test_sequential();
    run_table("seq", '{3'b000, 3'b000}, '{16'h0002, 16'h0004});
  endtask

  task automatic test_stall();
    run_table("stall", '{3'b001, 3'b001, 3'b001, 3'b000},
              '{16'h0100, 16'h0100, 16'h0100, 16'h0100});
  endtask

  task automatic test_wrap();
    run_table("wrap", '{3'b000, 3'b000}, '{16'hFFFE, 16'hFFFF});
  endtask

  task automatic test_align();
    // Misaligned load, stall holding the fault, aligned load clearing it.
    run_table("align", '{3'b000, 3'b001, 3'b000, 3'b000, 3'b000},
              '{16'h0007, 16'h0008, 16'h0008, 16'h0101, 16'h0202});
  endtask

  task automatic test_reset_mid();
    run_table("rst_mid", '{3'b000, 3'b000, 3'b011}, '{16'h0003, 16'h0040, 16'h0050});
  endtask

  task automatic test_sampling();
    exp_t e;
    drive(1'b0, 1'b0, 16'h0A0A);
    e = sb.pop_front();
    // Change the input mid-cycle; the register must not follow it.
    next_instruction_address = 16'h5555;
    #2;
    checks++;
    if (instruction_address !== e.pc) begin
      errors++; $display("FAIL sampling pc got %h exp %h", instruction_address, e.pc);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic r, s;
    logic [15:0] n;
    for (int i = 0; i < 40; i++) begin
      r = ($urandom_range(0, 15) == 0);
      s = ($urandom_range(0, 3) == 0);
      n = 16'($urandom);
      drive(r, s, n);
      e = sb.pop_front();
      checks += 3;
      if (instruction_address !== e.pc) begin
        errors++; $display("FAIL b2b[%0d] pc got %h exp %h", i, instruction_address, e.pc);
      end
      if (pc_plus_step !== e.step) begin
        errors++; $display("FAIL b2b[%0d] step got %h exp %h", i, pc_plus_step, e.step);
      end
      if (misaligned_fault !== e.fault) begin
        errors++; $display("FAIL b2b[%0d] fault got %b exp %b", i, misaligned_fault, e.fault);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_wrap();
    test_align();
    test_reset_mid();
    test_sampling();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover got %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
